mux_source_sequencer: RTL and testbench

Upstream feeder for the 8-bit three-way async mux/decoder (inputs `sel`, `cs`, `alpha`, `beta`, `gamma`). The block buffers one word from each of three valid/ready producer channels, schedules the buffered words round-robin, and drives the mux's `sel`/`cs` so that exactly one buffered channel is presented on the mux output at a time. The downstream consumer acknowledges each presented word with `out_ready`.

---
 rtl/mux_source_sequencer.sv | 92 +++++++++
 tb/tb_mux_source_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_source_sequencer.sv
// mux_source_sequencer: buffers one word per channel and round-robin drives sel/cs of a 3-way mux (optional MUX_SEQ_STATS_EN counters)
module mux_source_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             g_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [WIDTH-1:0] g_data,
  output logic             a_ready,
  output logic             b_ready,
  output logic             g_ready,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alpha,
  output logic [WIDTH-1:0] beta,
  output logic [WIDTH-1:0] gamma,
`ifdef MUX_SEQ_STATS_EN
  output logic [7:0]       cnt_alpha,
  output logic [7:0]       cnt_beta,
  output logic [7:0]       cnt_gamma,
`endif
  output logic [1:0]       sel,
  output logic             cs
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state;
  logic [2:0] full, valid, ready, acc, rel;
  logic [1:0] ptr, p1, p2, pick, nxt;
  logic       done;
  assign valid   = {g_valid, b_valid, a_valid};
  assign ready   = rst_n ? ~full : 3'b000;
  assign a_ready = ready[0];
  assign b_ready = ready[1];
  assign g_ready = ready[2];
  assign acc     = valid & ready;
  assign done    = (state == GRANT) && out_ready;
  assign rel     = done ? (3'b001 << sel) : 3'b000;
  assign p1      = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  assign p2      = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
  assign pick    = full[ptr] ? ptr : full[p1] ? p1 : p2;
  assign nxt     = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  // channel buffers: load on accept, frozen while full, released on grant completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= '0;
      alpha <= '0;
      beta  <= '0;
      gamma <= '0;
    end else begin
      full <= (full | acc) & ~rel;
      if (acc[0]) alpha <= a_data;
      if (acc[1]) beta  <= b_data;
      if (acc[2]) gamma <= g_data;
    end
  end
  // grant FSM: pick first full channel from ptr, hold until consumer acknowledges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      cs    <= 1'b0;
      ptr   <= 2'd0;
    end else if (state == IDLE) begin
      if (|full) begin
        state <= GRANT;
        sel   <= pick;
        cs    <= 1'b1;
      end
    end else if (out_ready) begin
      state <= IDLE;
      cs    <= 1'b0;
      ptr   <= nxt;
    end
  end
`ifdef MUX_SEQ_STATS_EN
  // completed-transfer counters, wrapping at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_alpha <= '0;
      cnt_beta  <= '0;
      cnt_gamma <= '0;
    end else begin
      if (rel[0]) cnt_alpha <= cnt_alpha + 8'd1;
      if (rel[1]) cnt_beta  <= cnt_beta + 8'd1;
      if (rel[2]) cnt_gamma <= cnt_gamma + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mux_source_sequencer.sv
// tb_mux_source_sequencer: scoreboard bench with per-channel word queues and a round-robin reference model
module tb_mux_source_sequencer;
  logic       clk = 0, rst_n = 0;
  logic       a_valid = 0, b_valid = 0, g_valid = 0, out_ready = 0;
  logic [7:0] a_data = 0, b_data = 0, g_data = 0;
  logic       a_ready, b_ready, g_ready, cs;
  logic [7:0] alpha, beta, gamma;
  logic [1:0] sel;
`ifdef MUX_SEQ_STATS_EN
  logic [7:0] cnt_alpha, cnt_beta, cnt_gamma;
`endif
  int checks = 0, errors = 0;
  mux_source_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .b_valid(b_valid), .g_valid(g_valid),
    .a_data(a_data), .b_data(b_data), .g_data(g_data),
    .a_ready(a_ready), .b_ready(b_ready), .g_ready(g_ready),
    .out_ready(out_ready),
    .alpha(alpha), .beta(beta), .gamma(gamma),
`ifdef MUX_SEQ_STATS_EN
    .cnt_alpha(cnt_alpha), .cnt_beta(cnt_beta), .cnt_gamma(cnt_gamma),
`endif
    .sel(sel), .cs(cs)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic int chdata(input int s);
    return s == 0 ? int'(alpha) : s == 1 ? int'(beta) : int'(gamma);
  endfunction
  // reference model: words waiting per channel, channel to start the next scan from
  logic [7:0] q[3][$];
  bit         mfull[3];
  int         rr = 0, mcnt[3];
  bit         exp_cs = 0;
  int         exp_sel = 0;
  // monitor: compare DUT against model, then advance model across the coming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        q[c].delete();
        mfull[c] = 0;
        mcnt[c]  = 0;
      end
      rr = 0;
      exp_cs = 0;
      exp_sel = 0;
    end else begin
      bit f[3];
      bit vld[3];
      logic [7:0] dat[3];
      int s;
      s = int'(sel);
      vld = '{a_valid, b_valid, g_valid};
      dat = '{a_data, b_data, g_data};
      chk("cs", int'(cs), int'(exp_cs));
      if (exp_cs) chk("sel", s, exp_sel);
      chk("a_ready", int'(a_ready), int'(!mfull[0]));
      chk("b_ready", int'(b_ready), int'(!mfull[1]));
      chk("g_ready", int'(g_ready), int'(!mfull[2]));
`ifdef MUX_SEQ_STATS_EN
      chk("cnt_alpha", int'(cnt_alpha), mcnt[0] % 256);
      chk("cnt_beta", int'(cnt_beta), mcnt[1] % 256);
      chk("cnt_gamma", int'(cnt_gamma), mcnt[2] % 256);
`endif
      if (cs && s < 3) begin
        if (q[s].size() == 0) chk("grant_of_empty_channel", s, -1);
        else chk("mux_data", chdata(s), int'(q[s][0]));
      end
      for (int c = 0; c < 3; c++) f[c] = mfull[c];
      if (!cs) begin
        exp_cs = 0;
        for (int k = 0; k < 3; k++)
          if (!exp_cs && f[(rr + k) % 3]) begin
            exp_cs = 1;
            exp_sel = (rr + k) % 3;
          end
      end else if (out_ready && s < 3) begin
        if (q[s].size() != 0) void'(q[s].pop_front());
        mfull[s] = 0;
        mcnt[s]++;
        rr = (s + 1) % 3;
        exp_cs = 0;
      end else begin
        exp_cs = 1;
        exp_sel = s;
      end
      for (int c = 0; c < 3; c++)
        if (vld[c] && !f[c]) begin
          q[c].push_back(dat[c]);
          mfull[c] = 1;
        end
    end
  end
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; g_valid = 0;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_cs"}, int'(cs), 0);
    chk({tag, "_sel"}, int'(sel), 0);
    chk({tag, "_readies"}, int'({a_ready, b_ready, g_ready}), 0);
    chk({tag, "_bufs"}, int'(alpha) + int'(beta) + int'(gamma), 0);
  endtask
  initial begin
    int n;
    step(2);
    check_zero("reset");
    rst_n = 1;
    step(2);
    // single beta word
    out_ready = 1;
    b_valid = 1; b_data = 8'h5A;
    step();
    b_valid = 0;
    step(5);
    // round robin: all three loaded together
    a_valid = 1; a_data = 8'h11;
    b_valid = 1; b_data = 8'h22;
    g_valid = 1; g_data = 8'h33;
    step();
    idle_inputs();
    step(10);
    // backpressure on alpha, new alpha data offered while full
    out_ready = 0;
    a_valid = 1; a_data = 8'hC3;
    step();
    a_data = 8'hFF;
    step(7);
    a_valid = 0;
    out_ready = 1;
    step(4);
    // pointer wrap: gamma in grant, alpha loaded, gamma refilled after completion
    out_ready = 0;
    g_valid = 1; g_data = 8'h77;
    step();
    g_valid = 0;
    a_valid = 1; a_data = 8'h44;
    step(3);
    a_valid = 0;
    out_ready = 1;
    g_valid = 1; g_data = 8'h88;
    step();
    out_ready = 0;
    step();
    g_valid = 0;
    step(3);
    out_ready = 1;
    step(8);
    // reset while gamma is being presented
    out_ready = 0;
    g_valid = 1; g_data = 8'h99;
    step();
    g_valid = 0;
    n = 0;
    while (!(cs && sel == 2'd2) && n < 10) begin
      step();
      n++;
    end
    chk("gamma_grant_before_reset", int'(cs && sel == 2'd2), 1);
    #2 rst_n = 0;
    #1 check_zero("async_reset");
    step();
    rst_n = 1;
    step(4);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a_valid = 1'($urandom_range(0, 1)); a_data = 8'($urandom);
      b_valid = 1'($urandom_range(0, 1)); b_data = 8'($urandom);
      g_valid = 1'($urandom_range(0, 1)); g_data = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle_inputs();
    out_ready = 1;
    step(10);
`ifdef MUX_SEQ_STATS_EN
    // 257 beta transfers from a clean reset
    #2 rst_n = 0;
    step();
    rst_n = 1;
    step();
    for (int i = 0; i < 257; i++) begin
      n = 0;
      while (!b_ready && n < 10) begin
        step();
        n++;
      end
      b_valid = 1; b_data = 8'($urandom);
      step();
      b_valid = 0;
    end
    step(6);
    chk("stats_cnt_beta", int'(cnt_beta), 1);
    chk("stats_cnt_alpha", int'(cnt_alpha), 0);
    chk("stats_cnt_gamma", int'(cnt_gamma), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
